// File: rtl/ppu_pkg.sv
// Shared types for the vblank commit buffer in front of the ppu register port.
package ppu_pkg;

  localparam logic [15:0] CTRL_COMMIT_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    DRAIN = 2'd2
  } vbc_state_t;

  typedef struct packed {
    logic [15:0] address;
    logic [31:0] writedata;
  } vbc_entry_t;

endpackage

// File: rtl/vbc_ram.sv
// Simple dual-port RAM: one write port, one registered read port, 48-bit entries.
module vbc_ram
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  vbc_entry_t    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output vbc_entry_t    rdata_o
);

  vbc_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vblank_commit.sv
// Host write buffer that replays committed register writes into the ppu during vblank.
// Optional feature: define VBLANK_COMMIT_COUNT_EN to build the completed-drain counter.
module vblank_commit
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  input  logic        vblank_start,
  output logic        ppu_chipselect,
  output logic        ppu_write,
  output logic [15:0] ppu_address,
  output logic [31:0] ppu_writedata,
  output logic        busy,
  output logic        pending,
  output logic [15:0] commit_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       cmt_ptr_q, cmt_ptr_d;
  ptr_t       rd_ptr_q, snap_ptr_q, rd_ptr_inc;
  vbc_state_t state_q;

  logic        host_wr, is_ctrl, is_commit, full, data_wr, drain_done;
  logic        ram_re;
  logic [AW-1:0] ram_raddr;
  vbc_entry_t  wr_entry, rd_entry;

  logic        ppu_cs_q, ppu_wr_q;
  logic [15:0] ppu_addr_q;
  logic [31:0] ppu_data_q;

  assign host_wr    = chipselect & write;
  assign is_ctrl    = (address == CTRL_COMMIT_ADDR);
  assign is_commit  = host_wr & is_ctrl;
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_wr    = host_wr & ~is_ctrl & ~full;
  assign waitrequest = host_wr & ~is_ctrl & full;
  assign pending    = (cmt_ptr_q != rd_ptr_q);
  assign busy       = (state_q != IDLE);

  assign rd_ptr_inc = rd_ptr_q + ptr_t'(1);
  assign drain_done = (state_q == DRAIN) && (rd_ptr_inc == snap_ptr_q);

  assign wr_entry.address   = address;
  assign wr_entry.writedata = writedata;

  // PRIME fetches the head; each DRAIN cycle prefetches the entry after the one it emits.
  assign ram_re    = (state_q != IDLE);
  assign ram_raddr = (state_q == PRIME) ? rd_ptr_q[AW-1:0] : rd_ptr_inc[AW-1:0];

  vbc_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (data_wr),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    if (data_wr)   wr_ptr_d  = wr_ptr_q + ptr_t'(1);
    if (is_commit) cmt_ptr_d = wr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      snap_ptr_q <= '0;
      ppu_cs_q   <= 1'b0;
      ppu_wr_q   <= 1'b0;
      ppu_addr_q <= '0;
      ppu_data_q <= '0;
    end else begin
      ppu_cs_q <= 1'b0;
      ppu_wr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Snapshot uses the registered commit point, so a same-cycle commit waits a frame.
          if (vblank_start && pending) begin
            snap_ptr_q <= cmt_ptr_q;
            state_q    <= PRIME;
          end
        end
        PRIME: state_q <= DRAIN;
        DRAIN: begin
          ppu_cs_q   <= 1'b1;
          ppu_wr_q   <= 1'b1;
          ppu_addr_q <= rd_entry.address;
          ppu_data_q <= rd_entry.writedata;
          rd_ptr_q   <= rd_ptr_inc;
          if (drain_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ppu_chipselect = ppu_cs_q;
  assign ppu_write      = ppu_wr_q;
  assign ppu_address    = ppu_addr_q;
  assign ppu_writedata  = ppu_data_q;

`ifdef VBLANK_COMMIT_COUNT_EN
  logic [15:0] commit_cnt_q, commit_cnt_d;

  assign commit_cnt_d = drain_done ? commit_cnt_q + 16'd1 : commit_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) commit_cnt_q <= '0;
    else        commit_cnt_q <= commit_cnt_d;
  end

  assign commit_count = commit_cnt_q;
`else
  assign commit_count = '0;
`endif

endmodule
